// File: rtl/fifo_sync.sv
// ----------------------------------------------------------------------------
// fifo_sync: parametrised single-clock FIFO backed by inferred block RAM.
// Push and pop are protected against full/empty. Almost thresholds are
// programmable. Sticky overflow/underflow flags record rejected requests.
// A synchronous flush clears contents, count and error flags.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   flush        in   synchronous clear (pointers, count, rvalid, error flags)
//   write/wdata  in   push request and data
//   read         in   pop request
//   rdata        out  popped word, valid the cycle after an accepted pop
//   rvalid       out  one-cycle strobe qualifying rdata
//   count        out  number of stored words
//   empty/full, almost_empty/almost_full  out  decodes of the count register
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
// ----------------------------------------------------------------------------
module fifo_sync #(
   parameter int unsigned DATA_WIDTH         = 8,
   parameter int unsigned DEPTH              = 1024,
   parameter int unsigned ALMOST_EMPTY_LEVEL = 1,
   parameter int unsigned ALMOST_FULL_LEVEL  = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   output logic                         empty,
   output logic                         almost_empty,
   input  logic                         read,
   output logic [DATA_WIDTH-1:0]        rdata,
   output logic                         rvalid,
   output logic                         full,
   output logic                         almost_full,
   input  logic                         write,
   input  logic [DATA_WIDTH-1:0]        wdata,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  empty_c;
   logic                  full_c;
   logic                  push_ok_c;
   logic                  pop_ok_c;

   // Status decodes of the registered count
   assign empty_c      = (count_q == '0);
   assign full_c       = (count_q == CW'(DEPTH));
   assign empty        = empty_c;
   assign full         = full_c;
   assign almost_empty = (count_q <= CW'(ALMOST_EMPTY_LEVEL));
   assign almost_full  = (count_q >= CW'(ALMOST_FULL_LEVEL));

   // Flush swallows any request issued in the same cycle
   assign push_ok_c = write && !full_c  && !flush;
   assign pop_ok_c  = read  && !empty_c && !flush;

   // Next-state for pointers, count and sticky error flags
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      rvalid_d    = pop_ok_c;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally
         if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_ok_c && !pop_ok_c)      count_d = count_q + CW'(1);
         else if (pop_ok_c && !push_ok_c) count_d = count_q - CW'(1);
         if (write && full_c) overflow_d  = 1'b1;
         if (read && empty_c) underflow_d = 1'b1;
      end
   end

   // Control state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rvalid_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rvalid_q    <= rvalid_d;
      end
   end

   // Storage array: no reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= wdata;
   end

   // Registered read port; holds its value between pops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (pop_ok_c) begin
         rdata_q <= mem_q[rd_ptr_q];
      end
   end

   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync.sv
// ----------------------------------------------------------------------------
// tb_fifo_sync: self-checking bench for fifo_sync (DEPTH=16, 8-bit, AE=1,
// AF=15). A queue-based reference model predicts every output after each
// clock edge; directed scenarios are followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_fifo_sync;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEP   = 16;
   localparam int unsigned AE    = 1;
   localparam int unsigned AF    = 15;
   localparam int unsigned CW    = $clog2(DEP) + 1;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          empty;
   logic          almost_empty;
   logic          read;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          full;
   logic          almost_full;
   logic          write;
   logic [DW-1:0] wdata;
   logic [CW-1:0] count;
   logic          overflow;
   logic          underflow;

   fifo_sync #(
      .DATA_WIDTH        (DW),
      .DEPTH             (DEP),
      .ALMOST_EMPTY_LEVEL(AE),
      .ALMOST_FULL_LEVEL (AF)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .empty       (empty),
      .almost_empty(almost_empty),
      .read        (read),
      .rdata       (rdata),
      .rvalid      (rvalid),
      .full        (full),
      .almost_full (almost_full),
      .write       (write),
      .wdata       (wdata),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [DW-1:0] mdl_q[$];
   logic          mdl_ovf;
   logic          mdl_unf;
   logic          mdl_rvalid;
   logic [DW-1:0] mdl_rdata;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      int sz;
      sz = mdl_q.size();
      check("count",        32'(count),        32'(sz));
      check("empty",        32'(empty),        32'(sz == 0));
      check("full",         32'(full),         32'(sz == DEP));
      check("almost_empty", 32'(almost_empty), 32'(sz <= AE));
      check("almost_full",  32'(almost_full),  32'(sz >= AF));
      check("overflow",     32'(overflow),     32'(mdl_ovf));
      check("underflow",    32'(underflow),    32'(mdl_unf));
      check("rvalid",       32'(rvalid),       32'(mdl_rvalid));
      check("rdata",        32'(rdata),        32'(mdl_rdata));
   endtask

   task automatic model_reset();
      mdl_q.delete();
      mdl_ovf    = 1'b0;
      mdl_unf    = 1'b0;
      mdl_rvalid = 1'b0;
      mdl_rdata  = '0;
   endtask

   // One clock edge of FIFO behaviour, judged on the state before the edge
   task automatic model_edge(input logic w, input logic r, input logic f, input logic [DW-1:0] wd);
      bit was_full, was_empty;
      if (f) begin
         mdl_q.delete();
         mdl_ovf    = 1'b0;
         mdl_unf    = 1'b0;
         mdl_rvalid = 1'b0;
      end else begin
         was_full  = (mdl_q.size() == DEP);
         was_empty = (mdl_q.size() == 0);
         if (w && was_full)  mdl_ovf = 1'b1;
         if (r && was_empty) mdl_unf = 1'b1;
         mdl_rvalid = 1'b0;
         if (r && !was_empty) begin
            mdl_rdata  = mdl_q.pop_front();
            mdl_rvalid = 1'b1;
         end
         if (w && !was_full) mdl_q.push_back(wd);
      end
   endtask

   task automatic step(input logic w, input logic r, input logic f, input logic [DW-1:0] wd);
      write = w;
      read  = r;
      flush = f;
      wdata = wd;
      @(posedge clk);
      model_edge(w, r, f, wd);
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      read  = 1'b0;
      write = 1'b0;
      wdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      check_all();
      reset = 1'b0;

      // Fill 0x00..0x0F, then drain in order
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Overflow while full, then simultaneous write+read at full
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, DW'(i));
      step(1'b1, 1'b0, 1'b0, 8'hAA);
      step(1'b1, 1'b1, 1'b0, 8'hBB);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00);

      // Underflow on empty, then write+read while empty
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 8'h55);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Pointer wrap with occupancy held at 5
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom));
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, DW'($urandom));

      // Fill, overflow, drain to 10, flush with a concurrent write
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom));
      step(1'b1, 1'b0, 1'b0, 8'hEE);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b1, 8'h77);
      step(1'b0, 1'b0, 1'b0, 8'h00);

      // Randomized traffic with occasional flush
      for (int i = 0; i < 800; i++) begin
         step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
              1'($urandom_range(0, 99) < 2), DW'($urandom));
      end

      // Async reset while a pop result is being presented
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, DW'(8'hC0 + i));
      step(1'b0, 1'b1, 1'b0, 8'h00);
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_all();
      step(1'b1, 1'b0, 1'b0, 8'h3C);
      step(1'b0, 1'b1, 1'b0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
Parametrised single-clock FIFO with inferred block RAM. It is the generic successor to the fixed 8-bit/1024-entry vendor-primitive FIFO and is used wherever the design needs width/depth other than 8x1024. Adds programmable almost thresholds, a synchronous flush, protected push/pop and sticky overflow/underflow error flags. Count and flags are always consistent with accepted operations only.

Parameters:
DATA_WIDTH, 8, word width in bits (1..64)
DEPTH, 1024, number of entries; power of two, 4..4096
ALMOST_EMPTY_LEVEL, 1, almost_empty asserted when count <= this value (0..DEPTH-1)
ALMOST_FULL_LEVEL, DEPTH-1, almost_full asserted when count >= this value (1..DEPTH)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of contents, count and error flags
empty  out  1  count == 0
almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL
read  in  1  pop request
rdata  out  DATA_WIDTH  read data, valid one cycle after accepted pop
rvalid  out  1  high for one cycle when rdata carries a popped word
full  out  1  count == DEPTH
almost_full  out  1  count >= ALMOST_FULL_LEVEL
write  in  1  push request
wdata  in  DATA_WIDTH  write data
count  out  $clog2(DEPTH)+1  number of stored words
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async assert, sync release): wr_ptr, rd_ptr, count = 0; empty=1, almost_empty=1, full=0, almost_full=(ALMOST_FULL_LEVEL==0 ? n/a : 0), rvalid=0, rdata=0, overflow=0, underflow=0. RAM contents not reset.
- Push accepted (push_ok) = write && !full. Pop accepted (pop_ok) = read && !empty. Both judged on registered state at the clock edge.
- Full + write + read same cycle: pop accepted, push rejected, overflow set. Empty + write + read: push accepted, pop rejected, underflow set.
- push_ok: RAM[wr_ptr] <= wdata; wr_ptr <= wr_ptr+1, wraps DEPTH-1 -> 0.
- pop_ok: rdata <= RAM[rd_ptr] next cycle, rvalid=1 that cycle; rd_ptr wraps DEPTH-1 -> 0. rdata holds last value when rvalid=0.
- count: +1 on push_ok only, -1 on pop_ok only, unchanged on both/neither. Never exceeds DEPTH, never below 0.
- Flags are combinational decodes of the count register; they update the cycle after the operation (1-cycle flag latency).
- Push into a word currently being popped is impossible (pointers differ unless empty/full).
- overflow/underflow: set on rejected request, remain set until flush or reset.
- flush: highest priority after reset; pointers, count, rvalid, overflow, underflow cleared next edge; write/read in the same cycle ignored and do not set error flags. rdata not cleared.
- Reset mid-operation: any in-flight pop output is dropped (rvalid=0).

Test Plan:
DEPTH=16, DATA_WIDTH=8, AE=1, AF=15.
1. After reset -> empty=1, almost_empty=1, full=0, count=0, overflow=underflow=0.
2. Push 0x00..0x0F back-to-back -> count increments 1..16; almost_empty drops when count=2; almost_full at count=15; full at 16. Pop 16 -> rdata 0x00..0x0F in order, each with rvalid one cycle after read.
3. Full, write 0xAA alone -> count stays 16, overflow=1, subsequent data 0x00..0x0F unchanged. Then write+read together -> count 15, rdata=0x00, overflow stays 1.
4. Empty, read alone -> underflow=1, rvalid=0; write 0x55 + read same cycle -> count=1, no rvalid; next pop returns 0x55.
5. Pointer wrap: 40 cycles of push+pop with count held at 5 -> count constant 5, data order preserved across wrap.
6. Fill 10 words, set overflow, pulse flush with write=1 -> next cycle count=0, empty=1, overflow=0, write ignored; async reset asserted mid-pop -> rvalid=0 immediately.
